// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory block responder.
// Holds the block FSM state enum, write-size codes and byte-lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } blk_state_t;

    localparam logic [1:0] SZ_4B = 2'd0;
    localparam logic [1:0] SZ_1B = 2'd1;
    localparam logic [1:0] SZ_2B = 2'd2;
    localparam logic [1:0] SZ_3B = 2'd3;

    localparam int BLOCK_BITS      = 256;
    localparam int WORDS_PER_BLOCK = 8;

    // Mask bit k enables byte lane k; lane 0 is bits [31:24].
    // A 3-byte write that would run past lane 3 writes nothing.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        unique case (size)
            SZ_4B: m = 4'b1111;
            SZ_1B: m = 4'b0001 << off;
            SZ_2B: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_3B: begin
                if (off == 2'd0)      m = 4'b0111;
                else if (off == 2'd1) m = 4'b1110;
                else                  m = 4'b0000;
            end
        endcase
        return m;
    endfunction

    // Spread right-justified write data so each enabled lane
    // finds its byte in the right position.
    function automatic logic [31:0] lane_data(
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic [31:0] data
    );
        logic [31:0] d;
        unique case (size)
            SZ_1B:   d = {4{data[7:0]}};
            SZ_2B:   d = {2{data[15:0]}};
            SZ_3B:   d = (off == 2'd1) ? {8'h00, data[23:0]}
                                       : {data[23:0], 8'h00};
            default: d = data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_block_responder_if.sv
// Core-to-data-memory bus: word port plus 256-bit block port.
// master = core / cache side, slave = memory responder side.
interface dmem_block_responder_if;
    import dmem_pkg::*;

    logic [31:0]           data_address_2DM;
    logic                  MemRead_2DM;
    logic                  MemWrite_2DM;
    logic [31:0]           data_write_2DM;
    logic [1:0]            data_write_size_2DM;
    logic [31:0]           data_read_fDM;
    logic [BLOCK_BITS-1:0] block_write_2DM;
    logic                  dBlkRead;
    logic                  dBlkWrite;
    logic [BLOCK_BITS-1:0] block_read_fDM;
    logic                  block_read_fDM_valid;
    logic                  block_write_fDM_valid;
    logic                  blk_busy;

    modport master (
        output data_address_2DM, MemRead_2DM, MemWrite_2DM,
        output data_write_2DM, data_write_size_2DM,
        output block_write_2DM, dBlkRead, dBlkWrite,
        input  data_read_fDM, block_read_fDM,
        input  block_read_fDM_valid, block_write_fDM_valid,
        input  blk_busy
    );

    modport slave (
        input  data_address_2DM, MemRead_2DM, MemWrite_2DM,
        input  data_write_2DM, data_write_size_2DM,
        input  block_write_2DM, dBlkRead, dBlkWrite,
        output data_read_fDM, block_read_fDM,
        output block_read_fDM_valid, block_write_fDM_valid,
        output blk_busy
    );

endinterface

// File: rtl/dmem_array.sv
// Block-organised storage: word port (async read, byte-masked write)
// and block port (async full read, sync full write); no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int BLOCK_ADDR_BITS = 10
) (
    input  logic                       clk,
    input  logic [BLOCK_ADDR_BITS+2:0] word_idx,
    input  logic [3:0]                 word_be,
    input  logic [31:0]                word_wdata,
    output logic [31:0]                word_rdata,
    input  logic [BLOCK_ADDR_BITS-1:0] blk_idx,
    input  logic                       blk_we,
    input  logic [BLOCK_BITS-1:0]      blk_wdata,
    output logic [BLOCK_BITS-1:0]      blk_rdata
);

    localparam int DEPTH = 1 << BLOCK_ADDR_BITS;

    logic [BLOCK_BITS-1:0]      mem [DEPTH];
    logic [BLOCK_ADDR_BITS-1:0] w_blk;
    logic [2:0]                 w_sel;
    logic [7:0]                 w_base;

    assign w_blk  = word_idx[BLOCK_ADDR_BITS+2:3];
    assign w_sel  = word_idx[2:0];
    assign w_base = {w_sel, 5'd0};

    assign word_rdata = mem[w_blk][w_base +: 32];
    assign blk_rdata  = mem[blk_idx];

    // The block write is placed last so it overrides a word write
    // to the same block on the same edge.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (word_be[k]) begin
                mem[w_blk][w_base + 8'(24 - 8 * k) +: 8]
                    <= word_wdata[24 - 8 * k +: 8];
            end
        end
        if (blk_we) begin
            mem[blk_idx] <= blk_wdata;
        end
    end

endmodule

// File: rtl/dmem_block_responder.sv
// Data-memory responder: word accesses every cycle, block reads/writes
// with fixed latency and one-cycle valid pulses. Ports: CLK, RESET, bus.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int BLOCK_ADDR_BITS = 10,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4
) (
    input logic                   CLK,
    input logic                   RESET,
    dmem_block_responder_if.slave bus
);

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    blk_state_t                 state;
    logic [3:0]                 cnt;
    logic [BLOCK_ADDR_BITS-1:0] blk_idx;
    logic [BLOCK_BITS-1:0]      wr_buf;
    logic [BLOCK_BITS-1:0]      rd_q;
    logic                       rd_valid_q;
    logic                       wr_valid_q;

    logic [BLOCK_BITS-1:0]      blk_rdata;
    logic [31:0]                word_rdata;
    logic [31:0]                word_wdata;
    logic [3:0]                 word_be;
    logic                       blk_commit;
    logic                       unused_addr;

    assign unused_addr =
        ^bus.data_address_2DM[31:BLOCK_ADDR_BITS+5];

    assign word_be = bus.MemWrite_2DM
        ? lane_mask(bus.data_write_size_2DM,
                    bus.data_address_2DM[1:0])
        : 4'b0000;

    assign word_wdata = lane_data(bus.data_write_size_2DM,
                                  bus.data_address_2DM[1:0],
                                  bus.data_write_2DM);

    // Commit only on the final wait cycle of a still-held request.
    assign blk_commit = !RESET && (state == WR_WAIT)
                     && (cnt == 4'd0) && bus.dBlkWrite;

    dmem_array #(
        .BLOCK_ADDR_BITS(BLOCK_ADDR_BITS)
    ) u_array (
        .clk       (CLK),
        .word_idx  (bus.data_address_2DM[BLOCK_ADDR_BITS+4:2]),
        .word_be   (word_be),
        .word_wdata(word_wdata),
        .word_rdata(word_rdata),
        .blk_idx   (blk_idx),
        .blk_we    (blk_commit),
        .blk_wdata (wr_buf),
        .blk_rdata (blk_rdata)
    );

    assign bus.data_read_fDM =
        bus.MemRead_2DM ? word_rdata : 32'd0;
    assign bus.block_read_fDM        = rd_q;
    assign bus.block_read_fDM_valid  = rd_valid_q;
    assign bus.block_write_fDM_valid = wr_valid_q;
    assign bus.blk_busy              = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.dBlkWrite) begin
                        blk_idx <= bus.data_address_2DM[BLOCK_ADDR_BITS+4:5];
                        wr_buf  <= bus.block_write_2DM;
                        cnt     <= WR_LOAD;
                        state   <= WR_WAIT;
                    end else if (bus.dBlkRead) begin
                        blk_idx <= bus.data_address_2DM[BLOCK_ADDR_BITS+4:5];
                        cnt     <= RD_LOAD;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!bus.dBlkRead) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rd_q       <= blk_rdata;
                        rd_valid_q <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (!bus.dBlkWrite) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        wr_valid_q <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_block_responder.sv
// Randomised self-checking bench for dmem_block_responder against a
// byte-addressed big-endian memory model.
module tb_dmem_block_responder;
    import dmem_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_block_responder_if bus();

    dmem_block_responder #(
        .BLOCK_ADDR_BITS(10),
        .READ_LATENCY   (LAT),
        .WRITE_LATENCY  (LAT)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl [32768];

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [14:0] b;
        b = {a[14:2], 2'b00};
        return {mdl[b], mdl[b + 15'd1], mdl[b + 15'd2], mdl[b + 15'd3]};
    endfunction

    // Big-endian: first byte of the field is its most significant.
    function automatic void m_write(input logic [31:0] a,
                                    input logic [31:0] d,
                                    input logic [1:0]  sz);
        int n;
        int s;
        logic [14:0] base;
        base = {a[14:2], 2'b00};
        n = (sz == 2'd0) ? 4 : int'(sz);
        case (sz)
            2'd0:    s = 0;
            2'd2:    s = a[1] ? 2 : 0;
            default: s = int'(a[1:0]);
        endcase
        if (s + n > 4) return;
        for (int i = 0; i < n; i++) begin
            mdl[base + 15'(s + i)] = d[8 * (n - 1 - i) +: 8];
        end
    endfunction

    function automatic logic [255:0] m_block(input logic [9:0] idx);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) begin
            b[32 * w +: 32] = m_word({17'd0, idx, 5'(w * 4)});
        end
        return b;
    endfunction

    function automatic void m_blkwrite(input logic [9:0] idx,
                                       input logic [255:0] d);
        for (int w = 0; w < 8; w++) begin
            m_write({17'd0, idx, 5'(w * 4)}, d[32 * w +: 32], 2'd0);
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        return {17'($urandom), 10'($urandom_range(0, 15)), 5'($urandom)};
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[32 * w +: 32] = $urandom;
        return b;
    endfunction

    // Called away from the rising edge; returns just after it.
    task automatic word_write(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [1:0]  sz);
        bus.data_address_2DM    = a;
        bus.data_write_2DM      = d;
        bus.data_write_size_2DM = sz;
        bus.MemWrite_2DM        = 1'b1;
        @(posedge clk);
        m_write(a, d, sz);
        #1;
        bus.MemWrite_2DM = 1'b0;
    endtask

    task automatic word_read_chk(input string tag,
                                 input logic [31:0] a,
                                 input logic [31:0] exp);
        bus.data_address_2DM = a;
        bus.MemRead_2DM      = 1'b1;
        #1;
        chk(tag, bus.data_read_fDM, exp);
        bus.MemRead_2DM = 1'b0;
    endtask

    // Full block transaction from an idle responder; optional word
    // writes into the same block while it waits.
    task automatic blk_op(input bit wr,
                          input logic [31:0] a,
                          input logic [255:0] d,
                          input bit noise,
                          input string tag);
        logic [9:0]  idx;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [1:0]  wsz;
        bit          do_wr;
        idx = a[14:5];
        bus.data_address_2DM = a;
        bus.block_write_2DM  = d;
        bus.dBlkWrite        = wr;
        bus.dBlkRead         = !wr;
        @(posedge clk);
        #1;
        for (int c = 0; c <= LAT + 1; c++) begin
            do_wr = noise && (c < (wr ? LAT : LAT - 1))
                 && ($urandom_range(0, 1) == 1);
            wa  = {17'($urandom), idx, 5'($urandom)};
            wd  = $urandom;
            wsz = 2'($urandom);
            bus.data_address_2DM    = do_wr ? wa : a;
            bus.data_write_2DM      = wd;
            bus.data_write_size_2DM = wsz;
            bus.MemWrite_2DM        = do_wr;
            bus.MemRead_2DM         = 1'b1;
            @(negedge clk);
            chk({tag, "_word"}, bus.data_read_fDM,
                m_word(bus.data_address_2DM));
            chk({tag, "_busy"}, bus.blk_busy, c <= LAT);
            chk({tag, "_rvld"}, bus.block_read_fDM_valid,
                !wr && c == LAT);
            chk({tag, "_wvld"}, bus.block_write_fDM_valid,
                wr && c == LAT);
            if (c == LAT) begin
                if (!wr) chk({tag, "_data"}, bus.block_read_fDM,
                             m_block(idx));
                bus.dBlkWrite = 1'b0;
                bus.dBlkRead  = 1'b0;
            end
            @(posedge clk);
            if (do_wr) m_write(wa, wd, wsz);
            if (wr && c == LAT - 1) m_blkwrite(idx, d);
            #1;
        end
        bus.MemWrite_2DM = 1'b0;
        bus.MemRead_2DM  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] pat;
        logic [31:0]  a;
        int           wv;
        int           rv;
        int           r;

        bus.data_address_2DM    = '0;
        bus.MemRead_2DM         = 1'b0;
        bus.MemWrite_2DM        = 1'b0;
        bus.data_write_2DM      = '0;
        bus.data_write_size_2DM = '0;
        bus.block_write_2DM     = '0;
        bus.dBlkRead            = 1'b0;
        bus.dBlkWrite           = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.blk_busy, 1'b0);
        chk("rst_rvld", bus.block_read_fDM_valid, 1'b0);
        chk("rst_wvld", bus.block_write_fDM_valid, 1'b0);
        chk("rst_rdat", bus.block_read_fDM, '0);
        chk("rst_word", bus.data_read_fDM, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int b = 0; b < 17; b++) begin
            for (int w = 0; w < 8; w++) begin
                word_write({17'd0, (b == 16) ? 10'h40 : 10'(b), 5'(w * 4)},
                           $urandom, 2'd0);
            end
        end

        word_write(32'h100, 32'hAABBCCDD, 2'd0);
        word_read_chk("w_size0", 32'h100, 32'hAABBCCDD);
        word_write(32'h102, 32'h11, 2'd1);
        word_read_chk("w_size1", 32'h100, 32'hAABB11DD);
        word_write(32'h100, 32'h2233, 2'd2);
        word_read_chk("w_size2", 32'h100, 32'h223311DD);
        word_write(32'h103, 32'h445566, 2'd3);
        word_read_chk("w_size3_bad", 32'h100, 32'h223311DD);
        word_write(32'h101, 32'h778899, 2'd3);
        word_read_chk("w_size3_ok", 32'h103, 32'h22778899);

        for (int i = 0; i < 8; i++) begin
            word_write(32'h800 + 32'(4 * i), 32'(i), 2'd0);
        end
        blk_op(1'b0, 32'h800, '0, 1'b0, "blkrd");
        chk("blkrd_w1", bus.block_read_fDM[63:32], 32'd1);
        chk("blkrd_w7", bus.block_read_fDM[255:224], 32'd7);

        pat = rand_blk();
        blk_op(1'b1, 32'h800, pat, 1'b0, "blkwr");
        word_read_chk("blkwr_w0", 32'h800, pat[31:0]);
        word_read_chk("blkwr_w5", 32'h814, pat[191:160]);
        @(posedge clk);
        #1;

        pat = rand_blk();
        bus.data_address_2DM = 32'h800;
        bus.block_write_2DM  = pat;
        bus.dBlkWrite        = 1'b1;
        bus.dBlkRead         = 1'b1;
        wv = -1;
        rv = -1;
        for (int c = 0; c < 30 && rv < 0; c++) begin
            @(negedge clk);
            if (bus.block_write_fDM_valid && wv < 0) begin
                wv = c;
                bus.dBlkWrite = 1'b0;
                m_blkwrite(10'h40, pat);
            end
            if (bus.block_read_fDM_valid && rv < 0) begin
                rv = c;
                bus.dBlkRead = 1'b0;
                chk("sim_rd_data", bus.block_read_fDM, pat);
            end
        end
        bus.dBlkWrite = 1'b0;
        bus.dBlkRead  = 1'b0;
        chk("sim_wr_cycle", wv, 5);
        chk("sim_rd_cycle", rv, 11);
        @(posedge clk);
        #1;

        bus.data_address_2DM = 32'h800;
        bus.block_write_2DM  = ~pat;
        bus.dBlkWrite        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", bus.blk_busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.dBlkWrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle", bus.blk_busy, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_novld", bus.block_write_fDM_valid, 1'b0);
        end
        for (int w = 0; w < 8; w++) begin
            word_read_chk("abort_mem", 32'h800 + 32'(4 * w),
                          pat[32 * w +: 32]);
        end
        @(posedge clk);
        #1;

        bus.data_address_2DM = 32'h800;
        bus.dBlkRead         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstrd_busy", bus.blk_busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.dBlkRead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstrd_rvld", bus.block_read_fDM_valid, 1'b0);
        chk("rstrd_wvld", bus.block_write_fDM_valid, 1'b0);
        chk("rstrd_busy0", bus.blk_busy, 1'b0);
        chk("rstrd_data", bus.block_read_fDM, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        blk_op(1'b0, 32'h800, '0, 1'b0, "post_rst");

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                word_write(rand_addr(), $urandom, 2'($urandom));
            end else if (r < 6) begin
                a = rand_addr();
                word_read_chk("rnd_rd", a, m_word(a));
                @(posedge clk);
                #1;
            end else if (r < 8) begin
                blk_op(1'b0, rand_addr(), '0, 1'b1, "rnd_br");
            end else begin
                blk_op(1'b1, rand_addr(), rand_blk(), 1'b1, "rnd_bw");
            end
        end

        for (int b = 0; b < 16; b++) begin
            a = {17'($urandom), 10'(b), 5'($urandom)};
            word_read_chk("final_rd", a, m_word(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
